gated_sr_latch_sequencer: RTL and testbench
===========================================

# gated_sr_latch_sequencer

Controller that shares one gated SR latch (ports s, r, e, q, notq) between two requesters. It arbitrates round-robin and drives a glitch-safe setup, enable-pulse and hold sequence on s/r/e. Readback then confirms the latch reached the requested state. It sits between the two requesting blocks and the gate-level gated SR latch, and it guarantees the forbidden s=r=1 combination is never driven.

## Interface
Parameters:
- SETUP_CYCLES, default 1: cycles s/r are driven with e=0 before the enable pulse (legal range 1..255).
- PULSE_CYCLES, default 2: cycles e is held high (legal range 1..255).
- HOLD_CYCLES, default 1: cycles s/r are held with e=0 after the pulse (legal range 1..255).

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  2  req[i] high requests a latch write; it must stay high until done with gnt[i].
- op  in  2  op[i]=1 means set (q→1), op[i]=0 means reset (q→0). Sampled at grant.
- gnt  out  2  one-hot grant, held for the whole transaction.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse ending a transaction.
- err  out  1  one-cycle pulse coincident with done when readback fails.
- s  out  1  latch set input.
- r  out  1  latch reset input.
- e  out  1  latch enable.
- q  in  1  latch output, synchronous to clk.
- notq  in  1  latch complementary output.

## Operation
- FSM states: IDLE → SETUP → PULSE → HOLD → CHECK → IDLE.
- IDLE:
  - Outputs: s=r=e=0, gnt=0.
  - If any req is high, grant one by round-robin, register op_q=op[winner], load the counter, and go to SETUP.
- Round-robin:
  - Pointer names the last granted requester.
  - When both requesters are high, the one not last granted wins. When only one is high, it wins.
  - After reset the pointer equals 1, so req[0] wins the first tie.
- SETUP: s=op_q, r=~op_q, e=0, for SETUP_CYCLES cycles.
- PULSE: s/r unchanged, e=1, for PULSE_CYCLES cycles.
- HOLD: s/r unchanged, e=0, for HOLD_CYCLES cycles.
- CHECK (one cycle):
  - s=r=e=0, gnt still asserted, done=1.
  - err=1 if q≠op_q, notq≠~op_q, or q==notq.
  - Round-robin pointer updates to the granted requester.
- Counter: 8-bit down-counter, loaded with N-1 on entry to each timed state; the state exits when the count is 0.
- Invariants, checked every cycle:
  - s&r==0 always.
  - e=1 only in PULSE.
  - s/r are constant over the SETUP..HOLD window.
  - gnt is one-hot or zero.
  - busy = (state≠IDLE).
- A req falling mid-transaction is ignored; the transaction completes. op changes after grant are ignored.
- Asynchronous reset at any point:
  - state=IDLE, s=r=e=0, gnt=0, busy=0, done=0, err=0, pointer=1, counter=0.
  - The latch keeps its content because e drops immediately.

## Timing
- A request sampled high in an IDLE cycle T gives gnt/busy high from T+1.
- done/err occur at T+1+SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES; with defaults this is T+5.
- gnt/busy drop in the cycle after done. There is at least one IDLE cycle between transactions, so back-to-back throughput is one write per SETUP+PULSE+HOLD+2 cycles.
- e rises exactly SETUP_CYCLES cycles after s/r become valid. s/r stay valid exactly HOLD_CYCLES cycles after e falls.
- q/notq are sampled only in CHECK, after HOLD_CYCLES of settling.

## Test plan
- Reset then single set: assert rst_n low then high, pulse req=01 with op=01.
  - Required: gnt=01 at T+1, s=1 r=0 from T+1, e=1 in cycles T+2..T+3, done=1 err=0 at T+5, q=1 notq=0 afterwards.
- Single reset via requester 1: req=10 with op=00 after a previous set.
  - Required: r=1 s=0 throughout, e pulse of 2 cycles, done at T+5, q=0.
- Contention: hold req=11 continuously with op=10.
  - Required: grants alternate 01,10,01,10; each has one IDLE gap; q ends 0,1,0,1 respectively; err never set.
- Fault readback: force q=notq=1 in CHECK.
  - Required: done=1 and err=1 in the same cycle; both are 0 the next cycle.
- Reset mid-PULSE: drop rst_n while e=1.
  - Required: e, s, r, gnt, busy are 0 within the same cycle (asynchronously). After release, the FSM is in IDLE and a new req=01 gets a grant normally.
- Parameter sweep with SETUP=3, PULSE=1, HOLD=4.
  - Required: done at T+9, e high for exactly 1 cycle, and s&r==0 asserted on every cycle.

Source files
------------

// File: rtl/gated_sr_latch_sequencer.sv
// Round-robin sequencer that shares one gated SR latch between two requesters.
// Drives setup / enable-pulse / hold on s, r, e and confirms the latch state by readback.
module gated_sr_latch_sequencer #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] op,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       s,
    output logic       r,
    output logic       e,
    input  logic       q,
    input  logic       notq
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

    // Readback is good only when q matches the request and notq is its true complement.
    function automatic logic readback_bad(input logic q_v, input logic notq_v, input logic op_v);
        readback_bad = (q_v != op_v) | (notq_v != ~op_v) | (q_v == notq_v);
    endfunction

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       ptr_r;
    logic       op_r;
    logic [1:0] gnt_r;
    logic       busy_r;
    logic       done_r;
    logic       s_r;
    logic       r_r;
    logic       e_r;
    logic       winner_s;
    logic       err_s;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        winner_s = 1'b0;
        if (req == 2'b11) begin
            winner_s = ~ptr_r;
        end else if (req[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // q/notq may only be trusted in CHECK, so err is formed from the live readback there.
    always_comb begin
        err_s = 1'b0;
        if (state_r == ST_CHECK) begin
            err_s = readback_bad(q, notq, op_r);
        end else begin
            err_s = 1'b0;
        end
    end

    // Sequencer FSM; s/r/e/gnt/busy/done are registered so e falls as soon as rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            ptr_r   <= 1'b1;
            op_r    <= 1'b0;
            gnt_r   <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= 1'b0;
            r_r     <= 1'b0;
            e_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    e_r    <= 1'b0;
                    if (req != 2'b00) begin
                        state_r <= ST_SETUP;
                        gnt_r   <= winner_s ? 2'b10 : 2'b01;
                        op_r    <= op[winner_s];
                        s_r     <= op[winner_s];
                        r_r     <= ~op[winner_s];
                        cnt_r   <= SETUP_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r  <= 2'b00;
                        busy_r <= 1'b0;
                        s_r    <= 1'b0;
                        r_r    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_PULSE;
                        e_r     <= 1'b1;
                        cnt_r   <= PULSE_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_HOLD;
                        e_r     <= 1'b0;
                        cnt_r   <= HOLD_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_CHECK;
                        s_r     <= 1'b0;
                        r_r     <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_CHECK: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    gnt_r   <= 2'b00;
                    busy_r  <= 1'b0;
                    ptr_r   <= gnt_r[1];
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                    gnt_r   <= 2'b00;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    s_r     <= 1'b0;
                    r_r     <= 1'b0;
                    e_r     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_s;
    assign s    = s_r;
    assign r    = r_r;
    assign e    = e_r;

endmodule

// File: tb/tb_gated_sr_latch_sequencer.sv
// Bench for gated_sr_latch_sequencer: default and swept-parameter instances share stimulus,
// each paired with a behavioural latch and a cycle-count reference model.
module tb_gated_sr_latch_sequencer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [1:0] op    = 2'b00;
    logic       stuck = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] gnt_w  [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       err_w  [2];
    logic       s_w    [2];
    logic       r_w    [2];
    logic       e_w    [2];
    logic       q_w    [2];
    logic       notq_w [2];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got %0h, expected %0h", name, inst, $time, act, expv);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int S = (g == 0) ? 1 : 3;
        localparam int P = (g == 0) ? 2 : 1;
        localparam int H = (g == 0) ? 1 : 4;
        localparam int L = S + P + H + 1;

        gated_sr_latch_sequencer #(
            .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)
        ) dut (
            .clk(clk), .rst_n(rst_n), .req(req), .op(op),
            .gnt(gnt_w[g]), .busy(busy_w[g]), .done(done_w[g]), .err(err_w[g]),
            .s(s_w[g]), .r(r_w[g]), .e(e_w[g]), .q(q_w[g]), .notq(notq_w[g])
        );

        // Gated SR latch, clocked; unaffected by the sequencer reset.
        logic lq = 1'b0;
        always @(posedge clk) begin
            if (e_w[g]) begin
                if (s_w[g] && !r_w[g]) lq <= 1'b1;
                else if (r_w[g] && !s_w[g]) lq <= 1'b0;
            end
        end
        assign q_w[g]    = stuck ? 1'b1 : lq;
        assign notq_w[g] = stuck ? 1'b1 : ~lq;

        // Reference: k counts cycles since grant; the transaction occupies k = 1..L.
        bit act  = 1'b0;
        int k    = 0;
        bit win  = 1'b0;
        bit mop  = 1'b0;
        bit last = 1'b1;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act  <= 1'b0;
                k    <= 0;
                last <= 1'b1;
            end else if (act) begin
                if (k == L) begin
                    act  <= 1'b0;
                    last <= win;
                end else begin
                    k <= k + 1;
                end
            end else if (req != 2'b00) begin
                win <= (req == 2'b11) ? !last : req[1];
                mop <= op[(req == 2'b11) ? !last : req[1]];
                act <= 1'b1;
                k   <= 1;
            end
        end

        logic [6:0] expv;
        logic [6:0] actv;
        logic       sr_on;
        logic       bad;
        always @(negedge clk) begin
            bad   = (q_w[g] !== mop) || (notq_w[g] !== !mop) || (q_w[g] === notq_w[g]);
            sr_on = act && (k <= S + P + H);
            if (act)
                expv = {(win ? 2'b10 : 2'b01), 1'b1, sr_on & mop, sr_on & !mop,
                        (k > S) && (k <= S + P), (k == L), (k == L) && bad};
            else
                expv = 7'd0;
            actv = {gnt_w[g], busy_w[g], s_w[g], r_w[g], e_w[g], done_w[g], err_w[g]};
            chk("outputs{gnt,busy,s,r,e,done,err}", g, 32'(actv), 32'(expv));
            chk("s_and_r_zero", g, 32'(s_w[g] & r_w[g]), 32'd0);
            chk("gnt_onehot0", g, 32'($onehot0(gnt_w[g])), 32'd1);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_w[0] || busy_w[1]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[0] || busy_w[1]) chk("wait_idle_timeout", 0, 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic run_one(input logic [1:0] rq, input logic [1:0] o,
                           output int lat0, output int lat1, output int ec0, output int ec1,
                           output logic [1:0] g1, output logic qd, output logic errd,
                           output logic errn, output logic donen);
        lat0 = -1; lat1 = -1; ec0 = 0; ec1 = 0; g1 = 2'b00;
        qd = 1'b0; errd = 1'b0; errn = 1'b1; donen = 1'b1;
        @(posedge clk);
        #2 req = rq; op = o;
        for (int n = 0; n < 40 && (lat1 < 0 || lat0 < 0 || n <= lat0 + 1); n++) begin
            @(negedge clk);
            if (n == 1) g1 = gnt_w[0];
            if (lat0 >= 0 && n == lat0 + 1) begin
                errn  = err_w[0];
                donen = done_w[0];
            end
            if (lat0 < 0 && e_w[0]) ec0++;
            if (lat1 < 0 && e_w[1]) ec1++;
            if (lat0 < 0 && done_w[0]) begin
                lat0 = n; qd = q_w[0]; errd = err_w[0]; req = 2'b00;
            end
            if (lat1 < 0 && done_w[1]) lat1 = n;
        end
        req = 2'b00;
        if (lat0 < 0 || lat1 < 0) chk("done_timeout", 0, 32'd1, 32'd0);
        wait_idle();
    endtask

    int         lat0, lat1, ec0, ec1, cnt, n;
    logic [1:0] g1;
    logic [1:0] gseq [4];
    logic       qseq [4];
    logic       qd, errd, errn, donen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 0, 32'(gnt_w[0]), 32'd0);
        chk("reset_busy", 0, 32'(busy_w[0]), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single set via requester 0.
        run_one(2'b01, 2'b01, lat0, lat1, ec0, ec1, g1, qd, errd, errn, donen);
        chk("set_gnt_T1", 0, 32'(g1), 32'd1);
        chk("set_done_lat", 0, 32'(lat0), 32'd5);
        chk("sweep_done_lat", 1, 32'(lat1), 32'd9);
        chk("set_e_cycles", 0, 32'(ec0), 32'd2);
        chk("sweep_e_cycles", 1, 32'(ec1), 32'd1);
        chk("set_q", 0, 32'(qd), 32'd1);
        chk("set_err", 0, 32'(errd), 32'd0);

        // Single reset via requester 1.
        run_one(2'b10, 2'b00, lat0, lat1, ec0, ec1, g1, qd, errd, errn, donen);
        chk("rst_gnt_T1", 0, 32'(g1), 32'd2);
        chk("rst_done_lat", 0, 32'(lat0), 32'd5);
        chk("rst_q", 0, 32'(qd), 32'd0);

        // Contention: grants must alternate starting with requester 0.
        @(posedge clk);
        #2 req = 2'b11; op = 2'b10;
        cnt = 0; n = 0;
        while (cnt < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (done_w[0]) begin
                gseq[cnt] = gnt_w[0];
                qseq[cnt] = q_w[0];
                cnt++;
            end
        end
        req = 2'b00;
        chk("contention_count", 0, 32'(cnt), 32'd4);
        for (int i = 0; i < 4 && i < cnt; i++) begin
            chk("contention_gnt", 0, 32'(gseq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("contention_q", 0, 32'(qseq[i]), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        wait_idle();

        // Readback fault: q and notq both stuck high.
        @(posedge clk);
        #2 stuck = 1'b1;
        run_one(2'b01, 2'b01, lat0, lat1, ec0, ec1, g1, qd, errd, errn, donen);
        chk("fault_err_at_done", 0, 32'(errd), 32'd1);
        chk("fault_err_next", 0, 32'(errn), 32'd0);
        chk("fault_done_next", 0, 32'(donen), 32'd0);
        @(posedge clk);
        #2 stuck = 1'b0;
        @(negedge clk);

        // Asynchronous reset while e is high.
        @(posedge clk);
        #2 req = 2'b01; op = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!e_w[0] && n < 20);
        chk("pulse_seen", 0, 32'(e_w[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_esrb", 0, 32'({e_w[0], s_w[0], r_w[0], busy_w[0]}), 32'd0);
        chk("async_rst_gnt", 0, 32'(gnt_w[0]), 32'd0);
        chk("latch_kept", 0, 32'(q_w[0]), 32'd1);
        req = 2'b00;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_one(2'b01, 2'b01, lat0, lat1, ec0, ec1, g1, qd, errd, errn, donen);
        chk("post_rst_gnt", 0, 32'(g1), 32'd1);
        chk("post_rst_lat", 0, 32'(lat0), 32'd5);

        // Random traffic, readback faults and occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 9) == 0) stuck = ~stuck;
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        req   = 2'b00;
        stuck = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
